// File: rtl/bcd_clock_timer_pkg.sv
// Shared types, BCD limits and segment table for the HH:MM:SS clock/timer.
// Also holds the per-field BCD increment/decrement helpers.
package bcd_clock_timer_pkg;

    typedef enum logic [1:0] {
        STOP    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } state_t;

    localparam logic [7:0] HOUR_MAX   = 8'h23;
    localparam logic [7:0] MINSEC_MAX = 8'h59;

    // Active-low {g,f,e,d,c,b,a}, index 9 down to 0
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
        7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic logic [7:0] bcd_inc(
        input logic [7:0] v,
        input logic [7:0] max
    );
        logic [7:0] r;
        if (v == max)
            r = 8'h00;
        else if (v[3:0] == 4'd9)
            r = {v[7:4] + 4'd1, 4'd0};
        else
            r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    function automatic logic [7:0] bcd_dec(
        input logic [7:0] v,
        input logic [7:0] max
    );
        logic [7:0] r;
        if (v == 8'h00)
            r = max;
        else if (v[3:0] == 4'd0)
            r = {v[7:4] - 4'd1, 4'd9};
        else
            r = {v[7:4], v[3:0] - 4'd1};
        return r;
    endfunction

endpackage

// File: rtl/bcd_clock_timer_if.sv
// Control inputs and display/status outputs of the clock/timer.
// master drives the controls, slave is the timer itself.
interface bcd_clock_timer_if;

    logic       pb;
    logic       mode;
    logic       fmt12;
    logic       swh;
    logic       swm;
    logic       sws;
    logic [6:0] hour1;
    logic [6:0] hour0;
    logic [6:0] min1;
    logic [6:0] min0;
    logic [6:0] sec1;
    logic [6:0] sec0;
    logic       pm;
    logic       running;
    logic       expired;

    modport master (
        output pb, mode, fmt12, swh, swm, sws,
        input  hour1, hour0, min1, min0, sec1, sec0,
        input  pm, running, expired
    );

    modport slave (
        input  pb, mode, fmt12, swh, swm, sws,
        output hour1, hour0, min1, min0, sec1, sec0,
        output pm, running, expired
    );

endinterface

// File: rtl/bcd_clock_timer_seg7_decode.sv
// One BCD digit to 7-segment pattern; non-decimal codes show blank.
// active_low=0 inverts the table for common-cathode displays.
module seg7_decode
    import bcd_clock_timer_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    input  logic       active_low,
    output logic [6:0] seg
);

    logic [6:0] pattern;

    always_comb begin
        pattern = SEG_BLANK;
        if (!blank && digit <= 4'd9)
            pattern = SEG_TABLE[digit];
        seg = active_low ? pattern : ~pattern;
    end

endmodule

// File: rtl/bcd_clock_timer.sv
// HH:MM:SS clock / countdown timer with debounced start/stop,
// auto-repeat field setting and direct 7-segment drive.
module bcd_clock_timer
    import bcd_clock_timer_pkg::*;
#(
    parameter int TICK_DIV       = 50_000_000,
    parameter int DB_CYC         = 500_000,
    parameter int SET_DIV        = 12_500_000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input logic              clk,
    input logic              rst,
    bcd_clock_timer_if.slave bus
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int DW = $clog2(DB_CYC + 1);
    localparam int SW = $clog2(SET_DIV + 1);

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DB_CYC - 1);
    localparam logic [SW-1:0] SET_LAST  = SW'(SET_DIV - 1);

    logic          pb_meta;
    logic          pb_sync;
    logic [2:0]    sw_meta;
    logic [2:0]    sw_sync;
    logic          db_level;
    logic [DW-1:0] db_cnt;
    logic          db_accept;
    logic          press;
    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic [SW-1:0] set_cnt;
    logic          set_any;
    logic          set_done;
    logic          set_inc;
    state_t        state_q;
    state_t        state_d;
    logic [23:0]   time_q;
    logic [23:0]   time_d;
    logic [7:0]    hour;
    logic [7:0]    min;
    logic [7:0]    sec;
    logic          last_sec;
    logic [7:0]    hour_disp;
    logic          hour_blank;

    assign hour = time_q[23:16];
    assign min  = time_q[15:8];
    assign sec  = time_q[7:0];

    // pb synchroniser idles released so reset cannot fake a press
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pb_meta <= 1'b1;
            pb_sync <= 1'b1;
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            pb_meta <= bus.pb;
            pb_sync <= pb_meta;
            sw_meta <= {bus.swh, bus.swm, bus.sws};
            sw_sync <= sw_meta;
        end
    end

    assign db_accept = (pb_sync != db_level) && (db_cnt == DB_LAST);
    assign press     = db_accept && !pb_sync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            db_level <= 1'b1;
            db_cnt   <= '0;
        end else if (pb_sync == db_level) begin
            db_cnt   <= '0;
        end else if (db_accept) begin
            db_level <= pb_sync;
            db_cnt   <= '0;
        end else begin
            db_cnt   <= db_cnt + 1'b1;
        end
    end

    assign tick = (state_q == RUN) && (tick_cnt == TICK_LAST);

    // Cleared whenever RUN is entered or left, so a run starts fresh
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            tick_cnt <= '0;
        else if (state_q != RUN || state_d != RUN || tick)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + 1'b1;
    end

    assign set_any  = |sw_sync;
    assign set_done = (state_q == STOP) && set_any &&
                      (set_cnt == SET_LAST);
    assign set_inc  = set_done && !press;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            set_cnt <= '0;
        else if (state_q != STOP || !set_any || set_done)
            set_cnt <= '0;
        else
            set_cnt <= set_cnt + 1'b1;
    end

    assign last_sec = (time_q <= 24'h000001);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_q <= STOP;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            STOP: begin
                if (press && !(bus.mode && time_q == 24'h0))
                    state_d = RUN;
            end
            RUN: begin
                if (press)
                    state_d = STOP;
                else if (tick && bus.mode && last_sec)
                    state_d = EXPIRED;
            end
            EXPIRED: begin
                if (press)
                    state_d = STOP;
            end
            default: state_d = STOP;
        endcase
    end

    always_comb begin
        time_d = time_q;
        if (state_q == RUN && tick && !press) begin
            if (!bus.mode) begin
                time_d[7:0] = bcd_inc(sec, MINSEC_MAX);
                if (sec == MINSEC_MAX) begin
                    time_d[15:8] = bcd_inc(min, MINSEC_MAX);
                    if (min == MINSEC_MAX)
                        time_d[23:16] = bcd_inc(hour, HOUR_MAX);
                end
            end else if (last_sec) begin
                time_d = '0;
            end else begin
                time_d[7:0] = bcd_dec(sec, MINSEC_MAX);
                if (sec == 8'h00) begin
                    time_d[15:8] = bcd_dec(min, MINSEC_MAX);
                    if (min == 8'h00)
                        time_d[23:16] = bcd_dec(hour, HOUR_MAX);
                end
            end
        end else if (set_inc) begin
            // Fields wrap on their own; no carry into the next field
            if (sw_sync[2])
                time_d[23:16] = bcd_inc(hour, HOUR_MAX);
            else if (sw_sync[1])
                time_d[15:8] = bcd_inc(min, MINSEC_MAX);
            else
                time_d[7:0] = bcd_inc(sec, MINSEC_MAX);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            time_q <= '0;
        else
            time_q <= time_d;
    end

    always_comb begin
        hour_disp = hour;
        if (bus.fmt12) begin
            unique case (hour)
                8'h00:   hour_disp = 8'h12;
                8'h20:   hour_disp = 8'h08;
                8'h21:   hour_disp = 8'h09;
                8'h22:   hour_disp = 8'h10;
                8'h23:   hour_disp = 8'h11;
                default: begin
                    if (hour > 8'h12)
                        hour_disp = hour - 8'h12;
                end
            endcase
        end
        hour_blank = bus.fmt12 && (hour_disp[7:4] == 4'd0);
    end

    assign bus.pm      = bus.fmt12 && (hour >= 8'h12);
    assign bus.running = (state_q == RUN);
    assign bus.expired = (state_q == EXPIRED);

    seg7_decode u_hour1 (
        .digit(hour_disp[7:4]), .blank(hour_blank),
        .active_low(SEG_ACTIVE_LOW), .seg(bus.hour1)
    );
    seg7_decode u_hour0 (
        .digit(hour_disp[3:0]), .blank(1'b0),
        .active_low(SEG_ACTIVE_LOW), .seg(bus.hour0)
    );
    seg7_decode u_min1 (
        .digit(min[7:4]), .blank(1'b0),
        .active_low(SEG_ACTIVE_LOW), .seg(bus.min1)
    );
    seg7_decode u_min0 (
        .digit(min[3:0]), .blank(1'b0),
        .active_low(SEG_ACTIVE_LOW), .seg(bus.min0)
    );
    seg7_decode u_sec1 (
        .digit(sec[7:4]), .blank(1'b0),
        .active_low(SEG_ACTIVE_LOW), .seg(bus.sec1)
    );
    seg7_decode u_sec0 (
        .digit(sec[3:0]), .blank(1'b0),
        .active_low(SEG_ACTIVE_LOW), .seg(bus.sec0)
    );

endmodule

// File: tb/tb_bcd_clock_timer.sv
// Directed bench for bcd_clock_timer with TICK_DIV=4, DB_CYC=3, SET_DIV=2.
// Inputs change on negedge; outputs are sampled on negedge.
module tb_bcd_clock_timer;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    bcd_clock_timer_if bus ();

    bcd_clock_timer #(
        .TICK_DIV(4),
        .DB_CYC(3),
        .SET_DIV(2),
        .SEG_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire [41:0] disp = {bus.hour1, bus.hour0, bus.min1,
                        bus.min0, bus.sec1, bus.sec0};

    function automatic logic [6:0] tb_seg(input int d);
        logic [6:0] r;
        case (d)
            0: r = 7'b1000000;
            1: r = 7'b1111001;
            2: r = 7'b0100100;
            3: r = 7'b0110000;
            4: r = 7'b0011001;
            5: r = 7'b0010010;
            6: r = 7'b0000010;
            7: r = 7'b1111000;
            8: r = 7'b0000000;
            9: r = 7'b0010000;
            default: r = 7'b1111111;
        endcase
        return r;
    endfunction

    function automatic logic [41:0] exp_disp(
        input int h, input int m, input int s, input bit f12
    );
        int hd;
        logic [6:0] h1;
        hd = h;
        if (f12) begin
            if (h == 0) hd = 12;
            else if (h > 12) hd = h - 12;
        end
        h1 = (f12 && hd / 10 == 0) ? 7'b1111111 : tb_seg(hd / 10);
        return {h1, tb_seg(hd % 10), tb_seg(m / 10), tb_seg(m % 10),
                tb_seg(s / 10), tb_seg(s % 10)};
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        bus.pb = 1'b1;
        bus.mode = 1'b0;
        bus.swh = 1'b0;
        bus.swm = 1'b0;
        bus.sws = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    // which: 0 hours, 1 minutes, 2 seconds, 3 hours+minutes
    task automatic set_field(input int which, input int n);
        if (n > 0) begin
            bus.swh = (which == 0 || which == 3);
            bus.swm = (which == 1 || which == 3);
            bus.sws = (which == 2);
            repeat (2 * n) @(negedge clk);
            bus.swh = 1'b0;
            bus.swm = 1'b0;
            bus.sws = 1'b0;
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic preset(input int h, input int m, input int s);
        set_field(0, h);
        set_field(1, m);
        set_field(2, s);
    endtask

    // Returns 6 cycles after pb falls; a run starts on the 5th edge
    task automatic do_press();
        bus.pb = 1'b0;
        repeat (6) @(negedge clk);
        bus.pb = 1'b1;
    endtask

    task automatic test_reset();
        bus.fmt12 = 1'b0;
        do_reset();
        total++;
        if (disp !== exp_disp(0, 0, 0, 0)) begin
            $display("FAIL reset_disp24 got=%h want=%h",
                     disp, exp_disp(0, 0, 0, 0));
            bad++;
        end
        total++;
        if ({bus.running, bus.expired, bus.pm} !== 3'b000) begin
            $display("FAIL reset_flags got=%b want=000",
                     {bus.running, bus.expired, bus.pm});
            bad++;
        end
        bus.fmt12 = 1'b1;
        @(negedge clk);
        total++;
        if ({disp, bus.pm} !== {exp_disp(0, 0, 0, 1), 1'b0}) begin
            $display("FAIL reset_disp12 got=%h/%b want=%h/0",
                     disp, bus.pm, exp_disp(0, 0, 0, 1));
            bad++;
        end
        bus.fmt12 = 1'b0;
    endtask

    task automatic test_set_hours();
        do_reset();
        preset(0, 5, 7);
        set_field(0, 23);
        total++;
        if (disp !== exp_disp(23, 5, 7, 0)) begin
            $display("FAIL set_hours23 got=%h want=%h",
                     disp, exp_disp(23, 5, 7, 0));
            bad++;
        end
        set_field(0, 1);
        total++;
        if (disp !== exp_disp(0, 5, 7, 0)) begin
            $display("FAIL set_hours_wrap got=%h want=%h",
                     disp, exp_disp(0, 5, 7, 0));
            bad++;
        end
    endtask

    task automatic test_set_priority();
        do_reset();
        preset(0, 4, 0);
        set_field(3, 3);
        total++;
        if (disp !== exp_disp(3, 4, 0, 0)) begin
            $display("FAIL set_priority got=%h want=%h",
                     disp, exp_disp(3, 4, 0, 0));
            bad++;
        end
        set_field(1, 56);
        total++;
        if (disp !== exp_disp(3, 0, 0, 0)) begin
            $display("FAIL set_min_wrap got=%h want=%h",
                     disp, exp_disp(3, 0, 0, 0));
            bad++;
        end
    endtask

    task automatic test_count_up_wrap();
        do_reset();
        preset(23, 59, 58);
        bus.mode = 1'b0;
        do_press();
        total++;
        if (bus.running !== 1'b1) begin
            $display("FAIL up_start running got=%b want=1", bus.running);
            bad++;
        end
        repeat (3) @(negedge clk);
        total++;
        if (disp !== exp_disp(23, 59, 59, 0)) begin
            $display("FAIL up_tick1 got=%h want=%h",
                     disp, exp_disp(23, 59, 59, 0));
            bad++;
        end
        repeat (4) @(negedge clk);
        total++;
        if ({disp, bus.running} !== {exp_disp(0, 0, 0, 0), 1'b1}) begin
            $display("FAIL up_wrap got=%h/%b want=%h/1",
                     disp, bus.running, exp_disp(0, 0, 0, 0));
            bad++;
        end
    endtask

    task automatic test_count_down();
        do_reset();
        preset(0, 1, 1);
        bus.mode = 1'b1;
        do_press();
        repeat (3) @(negedge clk);
        total++;
        if (disp !== exp_disp(0, 1, 0, 0)) begin
            $display("FAIL down_tick1 got=%h want=%h",
                     disp, exp_disp(0, 1, 0, 0));
            bad++;
        end
        repeat (4) @(negedge clk);
        total++;
        if (disp !== exp_disp(0, 0, 59, 0)) begin
            $display("FAIL down_borrow got=%h want=%h",
                     disp, exp_disp(0, 0, 59, 0));
            bad++;
        end
        repeat (58 * 4) @(negedge clk);
        total++;
        if ({disp, bus.running} !== {exp_disp(0, 0, 1, 0), 1'b1}) begin
            $display("FAIL down_tick60 got=%h/%b want=%h/1",
                     disp, bus.running, exp_disp(0, 0, 1, 0));
            bad++;
        end
        repeat (4) @(negedge clk);
        total++;
        if ({bus.running, bus.expired} !== 2'b01) begin
            $display("FAIL down_expire flags got=%b want=01",
                     {bus.running, bus.expired});
            bad++;
        end
        repeat (8) @(negedge clk);
        total++;
        if ({disp, bus.expired} !== {exp_disp(0, 0, 0, 0), 1'b1}) begin
            $display("FAIL down_frozen got=%h/%b want=%h/1",
                     disp, bus.expired, exp_disp(0, 0, 0, 0));
            bad++;
        end
        do_press();
        total++;
        if ({bus.running, bus.expired} !== 2'b00) begin
            $display("FAIL expired_press flags got=%b want=00",
                     {bus.running, bus.expired});
            bad++;
        end
    endtask

    task automatic test_down_zero_ignored();
        do_reset();
        bus.mode = 1'b1;
        do_press();
        repeat (4) @(negedge clk);
        total++;
        if ({bus.running, bus.expired} !== 2'b00) begin
            $display("FAIL zero_press flags got=%b want=00",
                     {bus.running, bus.expired});
            bad++;
        end
    endtask

    task automatic test_glitch();
        do_reset();
        bus.pb = 1'b0;
        repeat (2) @(negedge clk);
        bus.pb = 1'b1;
        repeat (10) @(negedge clk);
        total++;
        if (bus.running !== 1'b0) begin
            $display("FAIL pb_glitch running got=%b want=0", bus.running);
            bad++;
        end
        do_press();
        total++;
        if (bus.running !== 1'b1) begin
            $display("FAIL pb_after_glitch running got=%b want=1",
                     bus.running);
            bad++;
        end
    endtask

    task automatic test_fmt12();
        do_reset();
        preset(13, 5, 0);
        bus.fmt12 = 1'b1;
        @(negedge clk);
        total++;
        if ({disp, bus.pm} !== {exp_disp(13, 5, 0, 1), 1'b1}) begin
            $display("FAIL fmt12_13h got=%h/%b want=%h/1",
                     disp, bus.pm, exp_disp(13, 5, 0, 1));
            bad++;
        end
        bus.fmt12 = 1'b0;
        @(negedge clk);
        total++;
        if ({disp, bus.pm} !== {exp_disp(13, 5, 0, 0), 1'b0}) begin
            $display("FAIL fmt24_13h got=%h/%b want=%h/0",
                     disp, bus.pm, exp_disp(13, 5, 0, 0));
            bad++;
        end
        do_reset();
        bus.fmt12 = 1'b1;
        preset(0, 7, 0);
        total++;
        if ({disp, bus.pm} !== {exp_disp(0, 7, 0, 1), 1'b0}) begin
            $display("FAIL fmt12_00h got=%h/%b want=%h/0",
                     disp, bus.pm, exp_disp(0, 7, 0, 1));
            bad++;
        end
        set_field(0, 12);
        total++;
        if ({disp, bus.pm} !== {exp_disp(12, 7, 0, 1), 1'b1}) begin
            $display("FAIL fmt12_12h got=%h/%b want=%h/1",
                     disp, bus.pm, exp_disp(12, 7, 0, 1));
            bad++;
        end
        set_field(0, 11);
        total++;
        if ({disp, bus.pm} !== {exp_disp(23, 7, 0, 1), 1'b1}) begin
            $display("FAIL fmt12_23h got=%h/%b want=%h/1",
                     disp, bus.pm, exp_disp(23, 7, 0, 1));
            bad++;
        end
        bus.fmt12 = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        preset(10, 20, 30);
        do_press();
        repeat (3) @(negedge clk);
        total++;
        if (disp !== exp_disp(10, 20, 31, 0)) begin
            $display("FAIL midrun_tick got=%h want=%h",
                     disp, exp_disp(10, 20, 31, 0));
            bad++;
        end
        #2 rst = 1'b0;
        #1;
        total++;
        if ({disp, bus.running} !== {exp_disp(0, 0, 0, 0), 1'b0}) begin
            $display("FAIL async_reset got=%h/%b want=%h/0",
                     disp, bus.running, exp_disp(0, 0, 0, 0));
            bad++;
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        total++;
        if ({disp, bus.running} !== {exp_disp(0, 0, 0, 0), 1'b0}) begin
            $display("FAIL after_reset got=%h/%b want=%h/0",
                     disp, bus.running, exp_disp(0, 0, 0, 0));
            bad++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b0;
        bus.pb = 1'b1;
        bus.mode = 1'b0;
        bus.fmt12 = 1'b0;
        bus.swh = 1'b0;
        bus.swm = 1'b0;
        bus.sws = 1'b0;
        test_reset();
        test_set_hours();
        test_set_priority();
        test_count_up_wrap();
        test_count_down();
        test_down_zero_ignored();
        test_glitch();
        test_fmt12();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bcd_clock_timer.md
Name: bcd_clock_timer

Overview:
Second-generation hours/minutes/seconds block for the board display. It has one clock domain and uses a tick enable instead of a derived clock. Run modes are count-up clock and count-down timer with an expiry flag. Display is 24 h or 12 h (with PM flag), with debounced start/stop and auto-repeat field setting. It drives six 7-segment digits directly.

Parameters:
TICK_DIV, 50_000_000, clk cycles per 1 s tick (>=2)
DB_CYC, 500_000, cycles pb must be stable to be accepted (>=1)
SET_DIV, 12_500_000, cycles between auto-repeat increments while a set switch is held (>=1)
SEG_ACTIVE_LOW, 1, 1: segment on = 0; 0: inverted polarity

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
pb  in  1  raw start/stop push button, pressed = 0
mode  in  1  0 count-up clock, 1 count-down timer
fmt12  in  1  0 24 h display, 1 12 h display
swh  in  1  set hours (effective only when stopped)
swm  in  1  set minutes
sws  in  1  set seconds
hour1, hour0, min1, min0, sec1, sec0  out  7 each  segment patterns {g,f,e,d,c,b,a}
pm  out  1  high in 12 h mode when internal hour >= 12
running  out  1  high in RUN state
expired  out  1  high in EXPIRED state

Behaviour:
- Sync: pb, swh, swm, sws each pass a 2-flop synchroniser. The debouncer accepts a new pb level after DB_CYC consecutive equal samples. press = accepted 1->0 transition, a 1-cycle pulse.
- Time register: 24-bit packed BCD hh:mm:ss, always a legal 24 h value (hours 00-23, min/sec 00-59).
- State machine (STOP, RUN, EXPIRED), reset -> STOP, time 00:00:00.
- STOP + press -> RUN, except when mode=1 and time=00:00:00: press is ignored.
- RUN + press -> STOP, time holds.
- EXPIRED + press -> STOP, time stays 00:00:00.
- State changes on the clock edge after the press pulse.
- Tick divider: counts 0..TICK_DIV-1 in RUN only. It clears on entry to RUN, so the first tick comes TICK_DIV cycles after entry. It holds at 0 in STOP and EXPIRED.
- RUN, mode=0, on tick: +1 s with BCD carry. 23:59:59 -> 00:00:00, stays RUN.
- RUN, mode=1, on tick: -1 s with BCD borrow (00:01:00 -> 00:00:59, 01:00:00 -> 00:59:59). 00:00:01 -> 00:00:00 and the state -> EXPIRED on the same edge.
- mode may change at any time; the new direction applies from the next tick.
- Setting (STOP only): set_cnt counts while any synchronised set switch is high and clears when none is high.
- When set_cnt reaches SET_DIV-1, one field increments and set_cnt restarts.
- Priority swh > swm > sws. Increments are per-field with no carry: hour 23->00, minute/second 59->00.
- Set switches are ignored in RUN and EXPIRED.
- press and set_cnt terminal on the same cycle in STOP: the state change wins; no field increment.
- Display from the registered time, combinational decode. 24 h: digits direct, pm=0.
- 12 h: internal 00 -> 12 with pm=0; 01-11 unchanged, pm=0; 12 -> 12, pm=1; 13-23 -> h-12, pm=1.
- 12 h leading zero: hour1 is blanked (all segments off) when it is 0.
- Reset values, outputs, 24 h: all digits show "0" (1000000 when active-low), pm=0, running=0, expired=0.
- Reset values, outputs, 12 h: hour digits show "12", pm=0.
- Non-decimal digit codes cannot occur; the decoder maps them to blank.
- Reset mid-operation: all registers, including synchronisers, debouncer, divider and set_cnt, clear asynchronously. The debouncer's accepted level resets to 1 (released).

Decomposition:
- Shared package holds:
  - the state enum (STOP/RUN/EXPIRED);
  - BCD limit constants (HOUR_MAX 8'h23, MINSEC_MAX 8'h59);
  - digit-to-segment constant table (active-low patterns 0-9, BLANK).
- One sub-module, seg7_decode: 4-bit digit + blank + polarity in, 7-bit segments out, instantiated six times.
- Synchroniser/debounce, divider, FSM and BCD arithmetic stay in bcd_clock_timer.

Test Plan:
Params TICK_DIV=4, DB_CYC=3, SET_DIV=2.
- Reset, fmt12=0 -> all digits 1000000, running=0, expired=0. Set fmt12=1 -> hour1 blank, hour0 "1"... correction: hours show "12", pm=0.
- STOP, hold swh 48 cycles -> 24 hour increments, wrap 23->00; minutes/seconds unchanged.
- Hold swh+swm together -> only hours change.
- Preset 23:59:58, mode=0, press pb (low for >=3 cycles after sync) -> running=1. After 8 cycles, time 00:00:00, still RUN.
- Preset 00:01:01, mode=1, run -> 00:01:00, then 00:00:59 tick by tick. After 61 ticks: 00:00:00, expired=1, running=0, time frozen. Press -> expired=0, STOP.
- mode=1 at 00:00:00, press -> stays STOP.
- pb glitch low for 2 cycles -> no state change.
- Internal 13:05:00, fmt12=1 -> hour digits blank/"1", pm=1. Internal 00:xx -> "12", pm=0.
- Assert rst mid-RUN at 10:20:30 -> time 00:00:00 and STOP immediately, before the next clk edge.
